fetch_buffer: RTL and testbench
===============================

Name: fetch_buffer

Overview:
Instruction buffer between the instruction cache output and the register decode stage. It queues {pc, instruction} pairs through a valid/ready FIFO, so a decode stall does not lose fetched words. On a jump redirect it flushes its contents. It then discards stale fetch responses until the first word at the redirect target arrives, which removes wrong-path instructions before decode.

Parameters:
WORDSZ, 64, width of pc and redirect target
INSTSZ, 32, instruction width
DEPTH, 4, number of entries (power of two, >=2)
CNTW, $clog2(DEPTH)+1, occupancy counter width
DROPW, 16, width of dropped-word statistics counter

Ports:
clk  input  1  clock, all state updates on posedge
rst  input  1  asynchronous, active-low reset (0 = reset)
enq_valid  input  1  fetch word available
enq_ready  output  1  buffer accepts enq this cycle
enq_pc  input  WORDSZ  pc of fetched word
enq_instr  input  INSTSZ  fetched instruction
deq_valid  output  1  head entry valid for decode
deq_ready  input  1  decode consumes head this cycle
deq_pc  output  WORDSZ  pc of head entry
deq_instr  output  INSTSZ  instruction of head entry
deq_misaligned  output  1  head entry pc[1:0] != 0
flush  input  1  jump redirect, single-cycle pulse or held
flush_target  input  WORDSZ  redirect pc
draining  output  1  state == DRAIN
occupancy  output  CNTW  current entry count
drop_cnt  output  DROPW  saturating count of discarded stale words

Behaviour:
- Reset (rst=0, async): head=tail=0, count=0, state=RUN, target_q=0, drop_cnt=0. Outputs: deq_valid=0, enq_ready=0, draining=0, occupancy=0, deq_pc/deq_instr/deq_misaligned=0.
- enq_ready = rst && (state==DRAIN || count!=DEPTH). This is combinational and does not depend on deq_ready: there is no full-bypass.
- deq_valid = (count!=0) && !flush. deq_* are read combinationally from storage[head]. When deq_valid=0, deq_* keep the last head contents.
- Handshakes: an enq fires when enq_valid && enq_ready. A deq fires when deq_valid && deq_ready.
- Latency: a word enqueued into an empty buffer appears on deq at the next cycle. There is no empty-bypass.
- RUN, enq fires: storage[tail] <= {enq_pc, enq_instr, enq_pc[1:0]!=0}; tail increments mod DEPTH.
- Deq fires: head increments mod DEPTH.
- count: +1 on enq only, -1 on deq only, unchanged when both fire. When full, only deq can fire. When empty, only enq can fire.
- Pointer wrap: natural modulo DEPTH. Full vs empty is distinguished by count only.
- flush (any state) has the highest priority:
  - head=tail=count=0.
  - The enq offered that cycle is discarded and not counted in drop_cnt.
  - No deq fires.
  - target_q <= flush_target; state <= DRAIN.
- DRAIN, enq fires with enq_pc != target_q: the word is discarded and drop_cnt increments, saturating at all-ones.
- DRAIN, enq fires with enq_pc == target_q: the word is written as in RUN and state <= RUN in the same edge.
- DRAIN with no enq: state is held. Since count=0 in DRAIN, deq_valid=0.
- flush while in DRAIN: target_q is reloaded and the state stays DRAIN.
- Reset asserted mid-operation: immediate clear regardless of state. Partially tracked entries are lost.
- occupancy = count. draining = (state==DRAIN).

Test Plan:
- Reset then fill: rst low 2 cycles, then enq pcs 0x1000,0x1004,0x1008,0x100C with deq_ready=0 -> enq_ready=0 after the 4th, occupancy=4, deq_pc=0x1000.
- Streaming with wrap: deq_ready=1, enq 10 sequential words from 0x2000 -> deq order 0x2000..0x2024 with no gaps, occupancy steady at 1 after the first word, pointers wrap twice.
- Full with simultaneous deq: buffer full, enq_valid=1, deq_ready=1 -> only deq fires, occupancy 4->3, enq accepted the following cycle.
- Flush and drain: 3 entries held, flush with target 0x3000 -> deq_valid=0 next cycle, draining=1. Then enq 0x100C,0x1010 -> drop_cnt=2. Then enq 0x3000 -> draining=0, deq_pc=0x3000 next cycle.
- Double flush: flush target 0x4000, then flush target 0x5000 while draining, then enq 0x4000 -> word dropped (drop_cnt+1). Then enq 0x5000 -> accepted and state returns to RUN.
- Misaligned word and async reset: enq pc 0x6002 -> deq_misaligned=1. Then assert rst mid-cycle with 2 entries -> occupancy=0 and deq_valid=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_buffer.sv
// fetch_buffer: instruction queue between the I-cache response and decode.
// Holds {pc, instruction, misaligned} entries in a small circular FIFO, so a
// decode stall never loses fetched words. A jump redirect (flush) empties the
// queue. Fetch responses that do not match the redirect target are then
// discarded until the first word at the target arrives.
//
// Ports:
//   clk, rst                  clock; asynchronous active-low reset
//   enq_valid/ready/pc/instr  fetch-side valid/ready input
//   deq_valid/ready/pc/instr  decode-side valid/ready output
//   deq_misaligned            head entry pc[1:0] != 0
//   flush, flush_target       redirect request and its target pc
//   draining                  discarding stale words until the target arrives
//   occupancy                 current number of entries
//   drop_cnt                  saturating count of discarded stale words
module fetch_buffer #(
    parameter int unsigned WORDSZ = 64,
    parameter int unsigned INSTSZ = 32,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned CNTW   = $clog2(DEPTH) + 1,
    parameter int unsigned DROPW  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enq_valid,
    output logic              enq_ready,
    input  logic [WORDSZ-1:0] enq_pc,
    input  logic [INSTSZ-1:0] enq_instr,
    output logic              deq_valid,
    input  logic              deq_ready,
    output logic [WORDSZ-1:0] deq_pc,
    output logic [INSTSZ-1:0] deq_instr,
    output logic              deq_misaligned,
    input  logic              flush,
    input  logic [WORDSZ-1:0] flush_target,
    output logic              draining,
    output logic [CNTW-1:0]   occupancy,
    output logic [DROPW-1:0]  drop_cnt
);

    localparam int unsigned PTRW = $clog2(DEPTH);

    localparam logic [0:0] StRun   = 1'b0;
    localparam logic [0:0] StDrain = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [PTRW-1:0]   head_q, head_d;
    logic [PTRW-1:0]   tail_q, tail_d;
    logic [CNTW-1:0]   count_q, count_d;
    logic [WORDSZ-1:0] target_q, target_d;
    logic [DROPW-1:0]  drop_q, drop_d;

    logic [WORDSZ-1:0] pc_mem    [DEPTH];
    logic [INSTSZ-1:0] instr_mem [DEPTH];
    logic              mis_mem   [DEPTH];

    logic enq_fire;
    logic deq_fire;
    logic wr_en;

    // In DRAIN the queue is empty, so the fetch side is always accepted
    // (either written or dropped).
    assign enq_ready = rst && ((state_q == StDrain) || (count_q != CNTW'(DEPTH)));
    assign deq_valid = (count_q != '0) && !flush;

    assign enq_fire = enq_valid && enq_ready;
    assign deq_fire = deq_valid && deq_ready;

    assign deq_pc         = pc_mem[head_q];
    assign deq_instr      = instr_mem[head_q];
    assign deq_misaligned = mis_mem[head_q];

    assign draining  = (state_q == StDrain);
    assign occupancy = count_q;
    assign drop_cnt  = drop_q;

    always_comb begin
        state_d  = state_q;
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        target_d = target_q;
        drop_d   = drop_q;
        wr_en    = 1'b0;

        if (flush) begin
            // Redirect wins over everything; the word offered now is stale
            // by definition and is not counted as a drop.
            head_d   = '0;
            tail_d   = '0;
            count_d  = '0;
            target_d = flush_target;
            state_d  = StDrain;
        end else begin
            if (enq_fire) begin
                if ((state_q == StRun) || (enq_pc == target_q)) begin
                    wr_en   = 1'b1;
                    tail_d  = tail_q + PTRW'(1);
                    state_d = StRun;
                end else if (drop_q != '1) begin
                    drop_d = drop_q + DROPW'(1);
                end
            end
            if (deq_fire) begin
                head_d = head_q + PTRW'(1);
            end
            if (wr_en && !deq_fire) begin
                count_d = count_q + CNTW'(1);
            end else if (!wr_en && deq_fire) begin
                count_d = count_q - CNTW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StRun;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            target_q <= '0;
            drop_q   <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                pc_mem[i]    <= '0;
                instr_mem[i] <= '0;
                mis_mem[i]   <= 1'b0;
            end
        end else begin
            state_q  <= state_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            target_q <= target_d;
            drop_q   <= drop_d;
            if (wr_en) begin
                pc_mem[tail_q]    <= enq_pc;
                instr_mem[tail_q] <= enq_instr;
                mis_mem[tail_q]   <= (enq_pc[1:0] != 2'b00);
            end
        end
    end

endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer: a table of per-cycle vectors
// (inputs plus expected pre-edge outputs) followed by hand-written sequences
// for the misaligned flag and asynchronous reset.
module tb_fetch_buffer;

    localparam int unsigned WORDSZ = 64;
    localparam int unsigned INSTSZ = 32;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned CNTW   = $clog2(DEPTH) + 1;
    localparam int unsigned DROPW  = 16;

    logic              clk;
    logic              rst;
    logic              enq_valid;
    logic              enq_ready;
    logic [WORDSZ-1:0] enq_pc;
    logic [INSTSZ-1:0] enq_instr;
    logic              deq_valid;
    logic              deq_ready;
    logic [WORDSZ-1:0] deq_pc;
    logic [INSTSZ-1:0] deq_instr;
    logic              deq_misaligned;
    logic              flush;
    logic [WORDSZ-1:0] flush_target;
    logic              draining;
    logic [CNTW-1:0]   occupancy;
    logic [DROPW-1:0]  drop_cnt;

    fetch_buffer #(
        .WORDSZ(WORDSZ),
        .INSTSZ(INSTSZ),
        .DEPTH (DEPTH),
        .CNTW  (CNTW),
        .DROPW (DROPW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enq_valid     (enq_valid),
        .enq_ready     (enq_ready),
        .enq_pc        (enq_pc),
        .enq_instr     (enq_instr),
        .deq_valid     (deq_valid),
        .deq_ready     (deq_ready),
        .deq_pc        (deq_pc),
        .deq_instr     (deq_instr),
        .deq_misaligned(deq_misaligned),
        .flush         (flush),
        .flush_target  (flush_target),
        .draining      (draining),
        .occupancy     (occupancy),
        .drop_cnt      (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ev;
        logic [63:0] epc;
        logic        dr;
        logic        fl;
        logic [63:0] ft;
        logic        x_er;
        logic        x_dv;
        logic [63:0] x_pc;
        int          x_occ;
        logic        x_drain;
        int          x_drop;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp;
    int   n_fail;

    function automatic logic [INSTSZ-1:0] instr_of(input logic [63:0] pc);
        return {16'hC0DE, pc[15:0]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic ev, input logic [63:0] epc, input logic dr, input logic fl,
                       input logic [63:0] ft, input logic x_er, input logic x_dv,
                       input logic [63:0] x_pc, input int x_occ, input logic x_drain,
                       input int x_drop);
        vec_t v;
        v.ev = ev; v.epc = epc; v.dr = dr; v.fl = fl; v.ft = ft;
        v.x_er = x_er; v.x_dv = x_dv; v.x_pc = x_pc; v.x_occ = x_occ;
        v.x_drain = x_drain; v.x_drop = x_drop;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic ev, input logic [63:0] pc, input logic dr);
        enq_valid = ev;
        enq_pc    = pc;
        enq_instr = instr_of(pc);
        deq_ready = dr;
        flush     = 1'b0;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;

        // Expected values are what the outputs show just before the coming edge.
        //   ev  epc      dr fl ft       er dv pc       occ drn drop
        // Fill with decode stalled.
        add(1, 64'h1000, 0, 0, 64'h0,    1, 0, 64'h0,    0, 0, 0);
        add(1, 64'h1004, 0, 0, 64'h0,    1, 1, 64'h1000, 1, 0, 0);
        add(1, 64'h1008, 0, 0, 64'h0,    1, 1, 64'h1000, 2, 0, 0);
        add(1, 64'h100C, 0, 0, 64'h0,    1, 1, 64'h1000, 3, 0, 0);
        add(0, 64'h0,    0, 0, 64'h0,    0, 1, 64'h1000, 4, 0, 0);
        // Full with both sides active: only deq fires, enq accepted next cycle.
        add(1, 64'h1010, 1, 0, 64'h0,    0, 1, 64'h1000, 4, 0, 0);
        add(1, 64'h1010, 0, 0, 64'h0,    1, 1, 64'h1004, 3, 0, 0);
        add(0, 64'h0,    1, 0, 64'h0,    0, 1, 64'h1004, 4, 0, 0);
        // Flush with 3 entries held; offered word is not counted as a drop.
        add(1, 64'h1014, 1, 1, 64'h3000, 1, 0, 64'h0,    3, 0, 0);
        add(1, 64'h100C, 1, 0, 64'h0,    1, 0, 64'h0,    0, 1, 0);
        add(1, 64'h1010, 1, 0, 64'h0,    1, 0, 64'h0,    0, 1, 1);
        add(1, 64'h3000, 0, 0, 64'h0,    1, 0, 64'h0,    0, 1, 2);
        add(0, 64'h0,    1, 0, 64'h0,    1, 1, 64'h3000, 1, 0, 2);
        // Double flush: first target becomes stale.
        add(0, 64'h0,    0, 1, 64'h4000, 1, 0, 64'h0,    0, 0, 2);
        add(0, 64'h0,    0, 1, 64'h5000, 1, 0, 64'h0,    0, 1, 2);
        add(1, 64'h4000, 0, 0, 64'h0,    1, 0, 64'h0,    0, 1, 2);
        add(1, 64'h5000, 0, 0, 64'h0,    1, 0, 64'h0,    0, 1, 3);
        add(0, 64'h0,    1, 0, 64'h0,    1, 1, 64'h5000, 1, 0, 3);
        // Streaming 10 words; pointers wrap twice.
        add(1, 64'h2000, 1, 0, 64'h0,    1, 0, 64'h0,    0, 0, 3);
        for (int i = 1; i < 10; i++) begin
            add(1, 64'h2000 + 64'(4 * i), 1, 0, 64'h0, 1, 1, 64'h2000 + 64'(4 * (i - 1)),
                1, 0, 3);
        end
        add(0, 64'h0,    1, 0, 64'h0,    1, 1, 64'h2024, 1, 0, 3);
        add(0, 64'h0,    0, 0, 64'h0,    1, 0, 64'h0,    0, 0, 3);

        // Reset for two cycles; outputs are cleared.
        rst          = 1'b0;
        flush_target = '0;
        drive(1'b0, 64'h0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_enq_ready", 64'(enq_ready), 64'h0);
        check("rst_deq_valid", 64'(deq_valid), 64'h0);
        check("rst_occupancy", 64'(occupancy), 64'h0);
        check("rst_draining", 64'(draining), 64'h0);
        check("rst_deq_pc", deq_pc, 64'h0);
        check("rst_deq_instr", 64'(deq_instr), 64'h0);
        check("rst_drop_cnt", 64'(drop_cnt), 64'h0);
        rst = 1'b1;

        for (int k = 0; k < vecs.size(); k++) begin
            if (k != 0) @(negedge clk);
            drive(vecs[k].ev, vecs[k].epc, vecs[k].dr);
            flush        = vecs[k].fl;
            flush_target = vecs[k].ft;
            #1;
            check($sformatf("v%0d_enq_ready", k), 64'(enq_ready), 64'(vecs[k].x_er));
            check($sformatf("v%0d_deq_valid", k), 64'(deq_valid), 64'(vecs[k].x_dv));
            check($sformatf("v%0d_occupancy", k), 64'(occupancy), 64'(vecs[k].x_occ));
            check($sformatf("v%0d_draining", k), 64'(draining), 64'(vecs[k].x_drain));
            check($sformatf("v%0d_drop_cnt", k), 64'(drop_cnt), 64'(vecs[k].x_drop));
            if (vecs[k].x_dv) begin
                check($sformatf("v%0d_deq_pc", k), deq_pc, vecs[k].x_pc);
                check($sformatf("v%0d_deq_instr", k), 64'(deq_instr),
                      64'(instr_of(vecs[k].x_pc)));
                check($sformatf("v%0d_deq_mis", k), 64'(deq_misaligned), 64'h0);
            end
        end

        // Misaligned entry, then asynchronous reset between clock edges.
        @(negedge clk);
        drive(1'b1, 64'h6002, 1'b0);
        @(negedge clk);
        drive(1'b1, 64'h6008, 1'b0);
        @(negedge clk);
        drive(1'b0, 64'h0, 1'b0);
        #1;
        check("mis_occupancy", 64'(occupancy), 64'h2);
        check("mis_deq_pc", deq_pc, 64'h6002);
        check("mis_flag", 64'(deq_misaligned), 64'h1);
        #2;
        rst = 1'b0;
        #1;
        check("arst_occupancy", 64'(occupancy), 64'h0);
        check("arst_deq_valid", 64'(deq_valid), 64'h0);
        check("arst_enq_ready", 64'(enq_ready), 64'h0);
        check("arst_deq_mis", 64'(deq_misaligned), 64'h0);
        check("arst_drop_cnt", 64'(drop_cnt), 64'h0);

        // After reset: one-cycle latency into an empty buffer.
        @(negedge clk);
        rst = 1'b1;
        drive(1'b1, 64'h7000, 1'b0);
        #1;
        check("post_deq_valid0", 64'(deq_valid), 64'h0);
        check("post_enq_ready", 64'(enq_ready), 64'h1);
        @(negedge clk);
        drive(1'b0, 64'h0, 1'b1);
        #1;
        check("post_deq_valid1", 64'(deq_valid), 64'h1);
        check("post_deq_pc", deq_pc, 64'h7000);
        check("post_occupancy", 64'(occupancy), 64'h1);
        @(negedge clk);
        drive(1'b0, 64'h0, 1'b0);
        #1;
        check("post_empty", 64'(occupancy), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
